// File: rtl/mnist_pkg.sv
// Shared definitions for the MNIST inference sequencer: sequencer states and default sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mnist_pkg;

    localparam int N_IN_DEF    = 784;  // pixels per image / MAC steps per neuron
    localparam int N_OUT_DEF   = 10;   // output neurons (classes)
    localparam int ACC_W_DEF   = 24;   // signed accumulator width
    localparam int MAC_LAT_DEF = 2;    // cycles from last mac_en until acc_in is valid

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CLR   = 3'd2,
        S_MAC   = 3'd3,
        S_DRAIN = 3'd4,
        S_CMP   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

endpackage

// File: rtl/mnist_argmax.sv
// Running signed argmax over neuron accumulators; strict '>' so ties keep the lower index.
// Latency: best updates on the clock edge ending the cmp_en cycle; best_idx_nxt shows it a cycle early.
// Backpressure: none, single-cycle strobe interface.
// Ports: clk/rst_n, clr (restart search), cmp_en (sample acc), idx (index of acc),
//        acc (signed value), best_idx_nxt (index after this cycle's update).
module mnist_argmax
    import mnist_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int IDX_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    cmp_en,
    input  logic [IDX_W-1:0]        idx,
    input  logic signed [ACC_W-1:0] acc,
    output logic [IDX_W-1:0]        best_idx_nxt
);

    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W-1:0] best_val_q, best_val_d;
    logic [IDX_W-1:0]        best_idx_q, best_idx_d;

    always_comb begin
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        if (clr) begin
            best_val_d = ACC_MIN;
            best_idx_d = '0;
        end else if (cmp_en && (acc > best_val_q)) begin
            best_val_d = acc;
            best_idx_d = idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_val_q <= ACC_MIN;
            best_idx_q <= '0;
        end else begin
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
        end
    end

    assign best_idx_nxt = best_idx_d;

endmodule

// File: rtl/mnist_infer_sequencer.sv
// Sequences one MNIST inference: loads N_IN pixels, runs N_IN MACs per output neuron, argmaxes results.
// Latency: N_IN accepted pixels, then N_OUT*(N_IN+MAC_LAT+2) cycles from the last pixel to done.
// Backpressure: pix_ready only in LOAD; pix_valid low stalls LOAD indefinitely, compute never stalls.
// Ports: clk/rst_n; start; pix_valid/pix_data/pix_ready (pixel stream); buf_we/buf_addr/buf_wdata
//        (image buffer write); mac_clr/mac_en/in_addr/neu_idx (MAC control); acc_in (MAC result);
//        busy/done/digit (status and classification).
module mnist_infer_sequencer
    import mnist_pkg::*;
#(
    parameter int N_IN    = N_IN_DEF,
    parameter int N_OUT   = N_OUT_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int MAC_LAT = MAC_LAT_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    pix_valid,
    input  logic [7:0]              pix_data,
    output logic                    pix_ready,
    output logic                    buf_we,
    output logic [9:0]              buf_addr,
    output logic [7:0]              buf_wdata,
    output logic                    mac_clr,
    output logic                    mac_en,
    output logic [9:0]              in_addr,
    output logic [3:0]              neu_idx,
    input  logic signed [ACC_W-1:0] acc_in,
    output logic                    busy,
    output logic                    done,
    output logic [3:0]              digit
);

    localparam logic [9:0] PIX_LAST   = 10'(N_IN - 1);
    localparam logic [9:0] MAC_LAST   = 10'(N_IN - 1);
    localparam logic [9:0] DRAIN_LAST = 10'((MAC_LAT > 0) ? (MAC_LAT - 1) : 0);
    localparam logic [3:0] NEU_LAST   = 4'(N_OUT - 1);

    state_t     state_q, state_d;
    logic [9:0] pix_cnt_q, pix_cnt_d;
    logic [9:0] step_q, step_d;      // MAC address in MAC, elapsed drain cycles in DRAIN
    logic [3:0] neu_q, neu_d;
    logic       done_q, done_d;
    logic [3:0] digit_q, digit_d;
    logic       rst_sync_q;
    logic       start_ok;
    logic       arg_clr, arg_cmp;
    logic [3:0] best_idx_nxt;

    // Reset release is retimed through one flop. Every register is already at its reset
    // value when rst_n rises and only start can move the FSM out of IDLE, so gating start
    // is enough to make deassertion synchronous: start counts from the 2nd edge on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 1'b0;
        end else begin
            rst_sync_q <= 1'b1;
        end
    end

    assign start_ok = start & rst_sync_q;

    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        step_d    = step_q;
        neu_d     = neu_q;
        done_d    = done_q;
        digit_d   = digit_q;
        pix_ready = 1'b0;
        buf_we    = 1'b0;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        in_addr   = '0;
        busy      = 1'b0;
        arg_clr   = 1'b0;
        arg_cmp   = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    state_d   = S_LOAD;
                    done_d    = 1'b0;
                    pix_cnt_d = '0;
                    arg_clr   = 1'b1;
                end
            end
            S_LOAD: begin
                busy      = 1'b1;
                pix_ready = 1'b1;
                if (pix_valid) begin
                    buf_we = 1'b1;
                    if (pix_cnt_q == PIX_LAST) begin
                        // Park the pixel counter at 0 so buf_addr idles at 0.
                        pix_cnt_d = '0;
                        neu_d     = '0;
                        state_d   = S_CLR;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 10'd1;
                    end
                end
            end
            S_CLR: begin
                busy    = 1'b1;
                mac_clr = 1'b1;
                step_d  = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                busy    = 1'b1;
                mac_en  = 1'b1;
                in_addr = step_q;
                if (step_q == MAC_LAST) begin
                    step_d  = '0;
                    state_d = (MAC_LAT > 0) ? S_DRAIN : S_CMP;
                end else begin
                    step_d = step_q + 10'd1;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (step_q == DRAIN_LAST) begin
                    step_d  = '0;
                    state_d = S_CMP;
                end else begin
                    step_d = step_q + 10'd1;
                end
            end
            S_CMP: begin
                busy    = 1'b1;
                arg_cmp = 1'b1;
                if (neu_q == NEU_LAST) begin
                    // best_idx_nxt already includes this neuron's compare.
                    digit_d = best_idx_nxt;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    neu_d   = neu_q + 4'd1;
                    state_d = S_CLR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pix_cnt_q <= '0;
            step_q    <= '0;
            neu_q     <= '0;
            done_q    <= 1'b0;
            digit_q   <= '0;
        end else begin
            state_q   <= state_d;
            pix_cnt_q <= pix_cnt_d;
            step_q    <= step_d;
            neu_q     <= neu_d;
            done_q    <= done_d;
            digit_q   <= digit_d;
        end
    end

    mnist_argmax #(
        .ACC_W (ACC_W),
        .IDX_W (4)
    ) u_argmax (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (arg_clr),
        .cmp_en       (arg_cmp),
        .idx          (neu_q),
        .acc          (acc_in),
        .best_idx_nxt (best_idx_nxt)
    );

    assign buf_addr  = pix_cnt_q;
    assign buf_wdata = pix_data;
    assign neu_idx   = neu_q;
    assign done      = done_q;
    assign digit     = digit_q;

endmodule

// File: tb/tb_mnist_infer_sequencer.sv
// Self-checking bench for mnist_infer_sequencer: random pixels, table-driven MAC datapath model,
// per-cycle schedule model derived from the per-image timing rules, literal digit/latency pins.
module tb_mnist_infer_sequencer;

    localparam int N_IN    = 784;
    localparam int N_OUT   = 10;
    localparam int ACC_W   = 24;
    localparam int MAC_LAT = 2;
    localparam int PER     = N_IN + MAC_LAT + 2;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_COMP = 2;
    localparam int M_DONE = 3;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    start;
    logic                    pix_valid;
    logic [7:0]              pix_data;
    logic                    pix_ready;
    logic                    buf_we;
    logic [9:0]              buf_addr;
    logic [7:0]              buf_wdata;
    logic                    mac_clr;
    logic                    mac_en;
    logic [9:0]              in_addr;
    logic [3:0]              neu_idx;
    logic signed [ACC_W-1:0] acc_in;
    logic                    busy;
    logic                    done;
    logic [3:0]              digit;

    mnist_infer_sequencer #(
        .N_IN    (N_IN),
        .N_OUT   (N_OUT),
        .ACC_W   (ACC_W),
        .MAC_LAT (MAC_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .buf_we    (buf_we),
        .buf_addr  (buf_addr),
        .buf_wdata (buf_wdata),
        .mac_clr   (mac_clr),
        .mac_en    (mac_en),
        .in_addr   (in_addr),
        .neu_idx   (neu_idx),
        .acc_in    (acc_in),
        .busy      (busy),
        .done      (done),
        .digit     (digit)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- datapath model: result valid only MAC_LAT cycles after N_IN mac_en ----
    int acc_tab [N_OUT];
    int dp_cnt;
    int dp_since;
    int acc_sel;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_cnt   <= 0;
            dp_since <= 0;
        end else if (mac_clr) begin
            dp_cnt   <= 0;
            dp_since <= 0;
        end else if (mac_en) begin
            dp_cnt   <= dp_cnt + 1;
            dp_since <= 0;
        end else if (dp_since < 100) begin
            dp_since <= dp_since + 1;
        end
    end

    assign acc_sel = (int'(neu_idx) < N_OUT) ? acc_tab[neu_idx] : 0;
    // Before the result is ready the bus carries the largest positive value, which would win.
    assign acc_in  = (dp_cnt == N_IN && dp_since >= MAC_LAT) ? ACC_W'(acc_sel)
                                                             : {1'b0, {(ACC_W-1){1'b1}}};

    // ---------------- cycle counter and reset-release edge counter ----------------
    int cyc = 0;
    int edges_since_rel;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges_since_rel <= 0;
        else if (edges_since_rel < 3) edges_since_rel <= edges_since_rel + 1;
    end

    function automatic int ref_argmax();
        int best = acc_tab[0];
        int idx  = 0;
        for (int k = 1; k < N_OUT; k++) begin
            if (acc_tab[k] > best) begin
                best = acc_tab[k];
                idx  = k;
            end
        end
        return idx;
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    int m_mode = M_IDLE;
    int m_pix;
    int m_t;
    int exp_digit = 0;
    int we_pulses;
    int addr_hits [N_IN];

    always @(negedge clk) begin
        if (!rst_n) begin
            m_mode    = M_IDLE;
            exp_digit = 0;
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_digit", digit, 0);
            chk("rst_ready", pix_ready, 0);
            chk("rst_we", buf_we, 0);
            chk("rst_mac_en", mac_en, 0);
            chk("rst_mac_clr", mac_clr, 0);
        end else begin
            if (buf_we) begin
                we_pulses++;
                if (int'(buf_addr) < N_IN) addr_hits[buf_addr]++;
            end
            case (m_mode)
                M_IDLE, M_DONE: begin
                    chk("idle_busy", busy, 0);
                    chk("idle_done", done, (m_mode == M_DONE) ? 1 : 0);
                    chk("idle_digit", digit, exp_digit);
                    chk("idle_ready", pix_ready, 0);
                    chk("idle_we", buf_we, 0);
                    chk("idle_mac_en", mac_en, 0);
                    chk("idle_mac_clr", mac_clr, 0);
                    if (start && edges_since_rel >= 1) begin
                        m_mode    = M_LOAD;
                        m_pix     = 0;
                        we_pulses = 0;
                        for (int i = 0; i < N_IN; i++) addr_hits[i] = 0;
                    end
                end
                M_LOAD: begin
                    chk("load_busy", busy, 1);
                    chk("load_done", done, 0);
                    chk("load_ready", pix_ready, 1);
                    chk("load_mac_en", mac_en, 0);
                    chk("load_mac_clr", mac_clr, 0);
                    chk("load_we", buf_we, pix_valid);
                    if (pix_valid) begin
                        chk("load_addr", buf_addr, m_pix);
                        chk("load_wdata", buf_wdata, pix_data);
                        m_pix++;
                        if (m_pix == N_IN) begin
                            m_mode = M_COMP;
                            m_t    = 0;
                        end
                    end
                end
                default: begin
                    int ph;
                    int nk;
                    ph = m_t % PER;
                    nk = m_t / PER;
                    chk("comp_busy", busy, 1);
                    chk("comp_done", done, 0);
                    chk("comp_digit", digit, exp_digit);
                    chk("comp_ready", pix_ready, 0);
                    chk("comp_we", buf_we, 0);
                    chk("comp_neu", neu_idx, nk);
                    chk("comp_mac_clr", mac_clr, (ph == 0) ? 1 : 0);
                    chk("comp_mac_en", mac_en, (ph >= 1 && ph <= N_IN) ? 1 : 0);
                    if (ph >= 1 && ph <= N_IN) chk("comp_in_addr", in_addr, ph - 1);
                    m_t++;
                    if (m_t == N_OUT * PER) begin
                        m_mode    = M_DONE;
                        exp_digit = ref_argmax();
                    end
                end
            endcase
        end
    end

    // ---------------- stimulus ----------------
    int last_e;

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_done_cleared", done, 0);
        chk("start_busy", busy, 1);
    endtask

    task automatic load_pixels(input bit bp);
        int n  = 0;
        int it = 0;
        bit ph = 1'b1;
        bit took;
        while (n < N_IN && it < 4 * N_IN) begin
            pix_valid = bp ? ph : 1'b1;
            ph        = ~ph;
            pix_data  = 8'($urandom);
            took      = pix_valid && pix_ready;
            @(posedge clk); #1;
            it++;
            if (took) n++;
        end
        pix_valid = 1'b0;
        chk("load_count", n, N_IN);
        last_e = cyc;
    endtask

    task automatic finish_run(input bit mid_start, input int exp_dig, input string nm);
        int it = 0;
        if (mid_start) begin
            while (!(mac_en && neu_idx == 4'd2) && it < 3 * PER) begin
                @(posedge clk); #1;
                it++;
            end
            chk({nm, "_reach_mac"}, (mac_en && neu_idx == 4'd2) ? 1 : 0, 1);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        it = 0;
        while (!done && it < N_OUT * PER + 100) begin
            @(posedge clk); #1;
            it++;
        end
        chk({nm, "_done_seen"}, done, 1);
        chk({nm, "_latency"}, cyc - last_e, 7880);
        chk({nm, "_digit"}, digit, exp_dig);
        chk({nm, "_busy_done"}, busy, 0);
    endtask

    task automatic chk_reset_now(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_digit"}, digit, 0);
        chk({nm, "_mac_en"}, mac_en, 0);
        chk({nm, "_neu"}, neu_idx, 0);
        chk({nm, "_in_addr"}, in_addr, 0);
        chk({nm, "_buf_addr"}, buf_addr, 0);
        chk({nm, "_ready"}, pix_ready, 0);
    endtask

    initial begin
        int it;
        rst_n     = 1'b0;
        start     = 1'b0;
        pix_valid = 1'b0;
        pix_data  = 8'd0;
        for (int k = 0; k < N_OUT; k++) acc_tab[k] = 0;
        #2;
        chk_reset_now("por");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Nominal: start raised straight after release; only the 2nd edge may honour it.
        for (int k = 0; k < N_OUT; k++) acc_tab[k] = 100 * k;
        start = 1'b1;
        @(posedge clk); #1;
        chk("first_edge_ignored", busy, 0);
        do_start();
        load_pixels(1'b0);
        finish_run(1'b0, 9, "nominal");

        // Ties, launched from DONE, with a start pulse in the middle of MAC.
        for (int k = 0; k < N_OUT; k++) acc_tab[k] = -10;
        acc_tab[0] = 5; acc_tab[1] = 50; acc_tab[2] = 50; acc_tab[3] = 3;
        repeat (3) @(posedge clk); #1;
        chk("done_held", done, 1);
        chk("digit_held", digit, 9);
        do_start();
        chk("restart_digit_kept", digit, 9);
        load_pixels(1'b0);
        finish_run(1'b1, 1, "ties");

        // All negative, pixels offered every other cycle.
        for (int k = 0; k < N_OUT; k++) acc_tab[k] = -1000 + k;
        acc_tab[6] = -1;
        do_start();
        load_pixels(1'b1);
        chk("bp_we_pulses", we_pulses, N_IN);
        it = 0;
        for (int i = 0; i < N_IN; i++) if (addr_hits[i] != 1) it++;
        chk("bp_addr_gaps_dups", it, 0);
        finish_run(1'b0, 6, "neg");

        // Reset during MAC of neuron 4.
        for (int k = 0; k < N_OUT; k++) acc_tab[k] = int'($urandom_range(200000, 0)) - 100000;
        do_start();
        load_pixels(1'b0);
        it = 0;
        while (!(mac_en && neu_idx == 4'd4) && it < 6 * PER) begin
            @(posedge clk); #1;
            it++;
        end
        chk("rst_reach_n4", (mac_en && neu_idx == 4'd4) ? 1 : 0, 1);
        repeat ($urandom_range(200, 1)) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_now("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full run after the mid-run reset, random accumulators.
        for (int k = 0; k < N_OUT; k++) acc_tab[k] = int'($urandom_range(200000, 0)) - 100000;
        acc_tab[$urandom_range(N_OUT - 1, 0)] = 150000;
        do_start();
        load_pixels(1'b0);
        finish_run(1'b0, ref_argmax(), "after_rst");

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mnist_infer_sequencer.md
MNIST_INFER_SEQUENCER -- requirements
Module: mnist_infer_sequencer

Interface
REQ-001 SHALL have parameter N_IN, default 784, meaning pixels per image and MAC steps per output neuron.
REQ-002 SHALL have parameter N_OUT, default 10, meaning output neurons (classes).
REQ-003 SHALL have parameter ACC_W, default 24, meaning signed accumulator width.
REQ-004 SHALL have parameter MAC_LAT, default 2, meaning cycles from the last mac_en until acc_in is valid.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, meaning asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1, meaning a begin-inference request, sampled in IDLE or DONE only.
REQ-008 SHALL have port pix_valid, input, 1, meaning pixel_data is valid.
REQ-009 SHALL have port pix_data, input, 8, meaning an unsigned pixel.
REQ-010 SHALL have port pix_ready, output, 1, meaning the block accepts a pixel this cycle.
REQ-011 SHALL have ports buf_we (1), buf_addr (10), buf_wdata (8), all outputs, meaning the image-buffer write port.
REQ-012 SHALL have ports mac_clr (1), mac_en (1), in_addr (10), neu_idx (4), all outputs, meaning the MAC datapath control.
REQ-013 SHALL have port acc_in, input, ACC_W signed, meaning the datapath accumulator result.
REQ-014 SHALL have ports busy (1), done (1), digit (4), all outputs, meaning status and the classification result.

Function
REQ-015 SHALL implement states IDLE, LOAD, CLR, MAC, DRAIN, CMP, DONE.
REQ-016 SHALL leave IDLE or DONE for LOAD when start=1; it SHALL also clear done, set pix_cnt=0, and set best index and best value to 0 and to the most negative value.
REQ-017 SHALL ignore start in every other state.
REQ-018 SHALL drive pix_ready=1 only in LOAD; a pixel is accepted when pix_valid&&pix_ready.
REQ-019 SHALL, on acceptance, drive buf_we=1, buf_addr=pix_cnt and buf_wdata=pix_data combinationally in the same cycle, then increment pix_cnt.
REQ-020 SHALL go to CLR with neu_idx=0 after accepting pixel N_IN-1; stalls (pix_valid=0) SHALL hold state indefinitely.
REQ-021 SHALL spend exactly one cycle in CLR, with mac_clr=1 and mac_en=0.
REQ-022 SHALL spend exactly N_IN cycles in MAC, with mac_en=1 and in_addr counting 0..N_IN-1, one per cycle.
REQ-023 SHALL spend exactly MAC_LAT cycles in DRAIN, with mac_en=0.
REQ-024 SHALL spend one cycle in CMP, sampling acc_in and replacing best when acc_in > best (signed, strict); ties therefore keep the lower index.
REQ-025 SHALL go from CMP to CLR with neu_idx+1 when neu_idx<N_OUT-1; otherwise it SHALL go to DONE, load digit with the best index, and set done=1.
REQ-026 SHALL hold done=1 and digit stable in DONE until the next start.
REQ-027 SHALL drive busy=1 in LOAD, CLR, MAC, DRAIN and CMP, and busy=0 in IDLE and DONE.
REQ-028 SHALL, per image, take N_IN accepted pixels plus N_OUT*(N_IN+MAC_LAT+2) compute cycles from the final pixel to done; with defaults this is 7880 cycles.
REQ-029 SHALL keep mac_clr, mac_en and buf_we 0 in every state not named above.

Reset
REQ-030 SHALL, on rst_n=0, immediately force state IDLE and all counters to 0; outputs SHALL be pix_ready=0, buf_we=0, mac_clr=0, mac_en=0, busy=0, done=0, digit=0, neu_idx=0, in_addr=0, buf_addr=0.
REQ-031 SHALL, after reset is asserted mid-inference, restart from IDLE with no partial result retained.
REQ-032 SHALL apply deassertion synchronously to clk inside the block; first start is honoured on the 2nd clock edge after rst_n rises.

Structure
REQ-033 SHALL place the state enumeration and the default N_IN, N_OUT, ACC_W and MAC_LAT in the shared package mnist_pkg.
REQ-034 SHALL have one sub-module, mnist_argmax, which holds the best value and best index and performs the signed compare with update on the CMP strobe.

Verification
REQ-035 SHALL cover a nominal run: reset, start, 784 pixels with pix_valid always 1, and a datapath model returning acc 100*k for neuron k, requiring digit=9 and done exactly 7880 cycles after the last pixel.
REQ-036 SHALL cover ties: acc values {5,50,50,3,...} with all others -10, requiring digit=1.
REQ-037 SHALL cover all-negative accumulators (-1000+k for k≠6, and -1 for k=6), requiring digit=6.
REQ-038 SHALL cover backpressure: pix_valid toggled every other cycle, requiring buf_addr 0..783 with no gaps or duplicates and exactly 784 buf_we pulses.
REQ-039 SHALL cover reset during MAC of neuron 4, requiring all outputs at reset values immediately; a following full run SHALL then give the correct digit.
REQ-040 SHALL cover start asserted during MAC, requiring it to be ignored with no change to counters, and start in DONE, requiring a new LOAD with done cleared next cycle.
